// File: rtl/div_clk_meter_pkg.sv
// Shared types and constants for the divided-clock period/high-time meter.
package div_clk_meter_pkg;

    localparam int unsigned CNT_W_DEF = 16;
    localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_WAIT_LOW,
        ST_ARMED,
        ST_RUN
    } state_e;

endpackage

// File: rtl/div_clk_meter_sync_2ff.sv
// Generic two-stage synchronizer with a configurable reset value.
module sync_2ff #(
    parameter int unsigned    W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/div_clk_meter.sv
// Measures period and high time of a divided clock sampled as data.
// DIV_CLK_METER_SYNC_EN selects a two-flop synchronizer input stage.
module div_clk_meter
    import div_clk_meter_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_div_clk,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high,
    output logic             o_valid,
    output logic             o_ovf
);

    localparam logic [CNT_W-1:0] CNT_LIM =
        (CNT_W == CNT_W_DEF) ? CNT_W'(CNT_MAX) : {CNT_W{1'b1}};

    logic s;

`ifdef DIV_CLK_METER_SYNC_EN
    sync_2ff #(
        .W       (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (i_div_clk),
        .q   (s)
    );
`else
    logic s_q, s_in_d;

    always_comb s_in_d = i_div_clk;

    always_ff @(posedge clk) begin
        if (rst) s_q <= 1'b1;
        else     s_q <= s_in_d;
    end

    assign s = s_q;
`endif

    logic             s_d_q, s_d_d;
    logic             rise;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    assign rise = s & ~s_d_q;

    // Interval tracking: first rise opens, each later rise closes and reopens.
    always_comb begin
        s_d_d    = s;
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        hcnt_d   = hcnt_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        ovf_d    = ovf_q;

        case (state_q)
            ST_WAIT_LOW: begin
                if (!s) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (rise) begin
                    state_d = ST_RUN;
                    pcnt_d  = CNT_W'(1);
                    hcnt_d  = CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (rise) begin
                    period_d = pcnt_q;
                    high_d   = hcnt_q;
                    valid_d  = 1'b1;
                    pcnt_d   = CNT_W'(1);
                    hcnt_d   = CNT_W'(1);
                end else if (pcnt_q == CNT_LIM) begin
                    // Interval too long to represent: drop it and re-arm.
                    ovf_d   = 1'b1;
                    state_d = ST_WAIT_LOW;
                end else begin
                    pcnt_d = pcnt_q + CNT_W'(1);
                    if (s) hcnt_d = hcnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_WAIT_LOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_d_q    <= 1'b1;
            state_q  <= ST_WAIT_LOW;
            pcnt_q   <= '0;
            hcnt_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            s_d_q    <= s_d_d;
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            hcnt_q   <= hcnt_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign o_period = period_q;
    assign o_high   = high_q;
    assign o_valid  = valid_q;
    assign o_ovf    = ovf_q;

endmodule

// File: tb/tb_div_clk_meter.sv
// Self-checking bench for div_clk_meter: vector table, corner sequences, random pulses.
module tb_div_clk_meter;

`ifdef DIV_CLK_METER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic main_in = 1'b1;
    logic sm_in = 1'b0;

    always #10 clk = ~clk;

    logic [15:0] period, high;
    logic        valid, ovf;
    logic [3:0]  sm_period, sm_high;
    logic        sm_valid, sm_ovf;

    div_clk_meter #(.CNT_W(16)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .i_div_clk (main_in),
        .o_period  (period),
        .o_high    (high),
        .o_valid   (valid),
        .o_ovf     (ovf)
    );

    div_clk_meter #(.CNT_W(4)) u_small (
        .clk       (clk),
        .rst       (rst),
        .i_div_clk (sm_in),
        .o_period  (sm_period),
        .o_high    (sm_high),
        .o_valid   (sm_valid),
        .o_ovf     (sm_ovf)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int period;
        int high;
        int due;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   valid_seen    = 0;
    int   sm_valid_seen = 0;

    bit have_prev = 1'b0;
    int prev_p    = 0;
    int prev_h    = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard: every main-DUT valid must match the next expected interval on time.
    always @(negedge clk) begin
        if (valid) begin
            valid_seen++;
            if (expq.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                mon_e = expq.pop_front();
                check("period", int'(period), mon_e.period);
                check("high", int'(high), mon_e.high);
                check("latency_cycle", cyc, mon_e.due);
            end
        end else if (expq.size() > 0 && expq[0].due < cyc) begin
            check("missing_valid_at", cyc, expq[0].due);
            void'(expq.pop_front());
        end
        if (sm_valid) sm_valid_seen++;
    end

    task automatic drive(input logic v, input int n);
        repeat (n) begin
            @(negedge clk);
            main_in = v;
        end
    endtask

    task automatic sm_drive(input logic v, input int n);
        repeat (n) begin
            @(negedge clk);
            sm_in = v;
        end
    endtask

    // One high/low pulse; its rise closes the previously opened interval.
    task automatic pulse(input int h, input int l);
        @(negedge clk);
        main_in = 1'b1;
        if (have_prev) expq.push_back('{period: prev_p, high: prev_h, due: cyc + 1 + LAT});
        have_prev = 1'b1;
        prev_p    = h + l;
        prev_h    = h;
        drive(1'b1, h - 1);
        drive(1'b0, l);
    endtask

    task automatic idle(input int n);
        drive(1'b0, n);
        prev_p += n;
    endtask

    typedef struct {
        int h;
        int l;
        int n;
        int exp_p;
        int exp_h;
        int exp_nv;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int base;
        int w;

        vecs[0] = '{h: 5,  l: 5, n: 4, exp_p: 10, exp_h: 5,  exp_nv: 3};
        vecs[1] = '{h: 3,  l: 5, n: 4, exp_p: 8,  exp_h: 3,  exp_nv: 4};
        vecs[2] = '{h: 1,  l: 1, n: 6, exp_p: 2,  exp_h: 1,  exp_nv: 6};
        vecs[3] = '{h: 2,  l: 7, n: 3, exp_p: 9,  exp_h: 2,  exp_nv: 3};
        vecs[4] = '{h: 12, l: 1, n: 3, exp_p: 13, exp_h: 12, exp_nv: 3};

        repeat (3) @(negedge clk);
        check("rst_period", int'(period), 0);
        check("rst_high", int'(high), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_sm_ovf", int'(sm_ovf), 0);
        rst = 1'b0;

        // Small counter overflow while the main input stays tied high.
        sm_drive(1'b0, 3);
        sm_drive(1'b1, 2);
        sm_drive(1'b0, 10);
        check("sm_ovf_early", int'(sm_ovf), 0);
        sm_drive(1'b0, 13);
        check("sm_ovf_set", int'(sm_ovf), 1);
        check("sm_period_hold", int'(sm_period), 0);
        check("sm_high_hold", int'(sm_high), 0);
        check("sm_no_valid", sm_valid_seen, 0);
        repeat (4) begin
            sm_drive(1'b1, 2);
            sm_drive(1'b0, 2);
        end
        sm_drive(1'b0, 3);
        check("sm_resume_period", int'(sm_period), 4);
        check("sm_resume_high", int'(sm_high), 2);
        check("sm_resume_count", sm_valid_seen, 3);
        check("sm_ovf_sticky", int'(sm_ovf), 1);

        drive(1'b1, 60);
        check("tied_high_no_valid", valid_seen, 0);

        // Table of steady pulse trains, chained back to back.
        drive(1'b0, 5);
        for (int i = 0; i < 5; i++) begin
            base = valid_seen;
            for (int k = 0; k < vecs[i].n; k++) pulse(vecs[i].h, vecs[i].l);
            idle(LAT + 2);
            check($sformatf("vec%0d_period", i), int'(period), vecs[i].exp_p);
            check($sformatf("vec%0d_high", i), int'(high), vecs[i].exp_h);
            check($sformatf("vec%0d_nvalid", i), valid_seen - base, vecs[i].exp_nv);
        end

        // Reset in the middle of a 4/4 interval.
        repeat (3) pulse(4, 4);
        pulse(4, 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_period", int'(period), 0);
        check("midrst_high", int'(high), 0);
        check("midrst_valid", int'(valid), 0);
        check("midrst_ovf", int'(ovf), 0);
        have_prev = 1'b0;
        base = valid_seen;
        drive(1'b0, 2);
        repeat (3) pulse(4, 4);
        idle(LAT + 2);
        check("after_rst_nvalid", valid_seen - base, 2);
        check("after_rst_period", int'(period), 8);
        check("after_rst_high", int'(high), 4);

        // Random pulse train against the interval model.
        for (int i = 0; i < 40; i++) pulse($urandom_range(1, 12), $urandom_range(1, 12));
        idle(4);

        w = 0;
        while (expq.size() > 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("queue_drained", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
